// File: rtl/interboard_pkg.sv
// interboard_pkg: shared types and helpers for the interboard link.
//   - TX/RX state enums
//   - clog2 used to size word indices and timeout counters
//   - checksum word index / frame length helpers
// Optional feature macro: INTERBOARD_CHECKSUM_EN (adds one XOR word per frame).
package interboard_pkg;

  typedef enum logic [1:0] {TX_IDLE, TX_SETUP, TX_REQ, TX_REL} tx_state_e;
  typedef enum logic       {RX_WAIT_REQ, RX_ACK}               rx_state_e;

  // Ceil(log2(v)), never less than 1 so that counters always have a bit.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((r < 32) && ((64'd1 << r) < 64'(v))) r++;
    return (r == 0) ? 32'd1 : r;
  endfunction

  // The checksum word follows the last payload word.
  function automatic int unsigned chk_word_idx(input int unsigned msg_words);
    return msg_words;
  endfunction

  // Words moved per frame, including the checksum word when enabled.
  function automatic int unsigned frame_words(input int unsigned msg_words);
`ifdef INTERBOARD_CHECKSUM_EN
    return msg_words + 1;
`else
    return msg_words;
`endif
  endfunction

endpackage

// File: rtl/interboard_sync.sv
// interboard_sync: STAGES-deep flip-flop synchroniser for one asynchronous bit.
//   clk  : system clock
//   rst  : synchronous active-high reset, clears all stages to 0
//   d_i  : asynchronous input
//   q_o  : synchronised output (STAGES cycles of latency)
module interboard_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] ff_q;

  always_ff @(posedge clk) begin
    if (rst) ff_q <= '0;
    else     ff_q <= {ff_q[STAGES-2:0], d_i};
  end

  assign q_o = ff_q[STAGES-1];

endmodule

// File: rtl/interboard_link_n.sv
// interboard_link_n: full-duplex 4-phase Request/Ack frame link between boards.
// A frame of MSG_WORDS words (word 0 = tx_msg[DATA_W-1:0], sent first) is moved
// one DATA_W word per handshake. TX and RX channels are independent.
// Optional feature macro: INTERBOARD_CHECKSUM_EN -- TX appends the XOR of all
// payload words; RX checks it and pulses rx_err instead of rx_valid on mismatch.
// Ports:
//   clk, rst                     : clock, synchronous active-high reset
//   tx_valid/tx_msg/tx_ready     : frame submit (accepted only while tx_ready)
//   tx_done/tx_timeout           : 1-cycle completion / abort pulses
//   Request_in/Ack_in            : asynchronous peer handshake inputs
//   inter_data_in                : peer data word
//   Request_out/Ack_out          : our handshake outputs
//   inter_data_out               : our data word (held while idle)
//   rx_valid/rx_msg/rx_err       : received frame, held until next rx_valid
module interboard_link_n
  import interboard_pkg::*;
#(
  parameter int unsigned DATA_W      = 6,
  parameter int unsigned MSG_WORDS   = 4,
  parameter int unsigned TIMEOUT_CYC = 1000000,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        tx_valid,
  input  logic [MSG_WORDS*DATA_W-1:0] tx_msg,
  output logic                        tx_ready,
  output logic                        tx_done,
  output logic                        tx_timeout,
  input  logic                        Request_in,
  input  logic                        Ack_in,
  input  logic [DATA_W-1:0]           inter_data_in,
  output logic                        Request_out,
  output logic                        Ack_out,
  output logic [DATA_W-1:0]           inter_data_out,
  output logic                        rx_valid,
  output logic [MSG_WORDS*DATA_W-1:0] rx_msg,
  output logic                        rx_err
);

  localparam int unsigned FRAME_W = frame_words(MSG_WORDS);
  localparam int unsigned IDX_W   = clog2(FRAME_W);
  localparam int unsigned CNT_W   = clog2(TIMEOUT_CYC);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_W - 1);
  localparam logic [CNT_W-1:0] TO_MAX   = CNT_W'(TIMEOUT_CYC - 1);
`ifdef INTERBOARD_CHECKSUM_EN
  localparam int unsigned CHK_IDX = chk_word_idx(MSG_WORDS);
`endif

  // Synchronised peer handshake lines.
  logic req_s, ack_s;

  interboard_sync #(.STAGES(SYNC_STAGES)) u_sync_req (
    .clk(clk), .rst(rst), .d_i(Request_in), .q_o(req_s)
  );
  interboard_sync #(.STAGES(SYNC_STAGES)) u_sync_ack (
    .clk(clk), .rst(rst), .d_i(Ack_in), .q_o(ack_s)
  );

  // ---------------- TX channel ----------------
  tx_state_e                       tx_state_q;
  logic [FRAME_W-1:0][DATA_W-1:0]  tx_frame_q, tx_frame_d;
  logic [IDX_W-1:0]                tx_wi_q;
  logic [CNT_W-1:0]                tx_cnt_q;
  logic                            tx_ready_q, tx_done_q, tx_to_q, req_q;
  logic [DATA_W-1:0]               dout_q;

  // Frame image built from tx_msg; latched as a whole on accept.
  always_comb begin
    tx_frame_d = '0;
    for (int i = 0; i < int'(MSG_WORDS); i++) begin
      tx_frame_d[i] = tx_msg[i*DATA_W +: DATA_W];
`ifdef INTERBOARD_CHECKSUM_EN
      tx_frame_d[CHK_IDX] = tx_frame_d[CHK_IDX] ^ tx_msg[i*DATA_W +: DATA_W];
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q <= TX_IDLE;
      tx_frame_q <= '0;
      tx_wi_q    <= '0;
      tx_cnt_q   <= '0;
      tx_ready_q <= 1'b1;
      tx_done_q  <= 1'b0;
      tx_to_q    <= 1'b0;
      req_q      <= 1'b0;
      dout_q     <= '0;
    end else begin
      tx_done_q <= 1'b0;
      tx_to_q   <= 1'b0;
      unique case (tx_state_q)
        TX_IDLE: if (tx_valid) begin
          tx_frame_q <= tx_frame_d;
          tx_wi_q    <= '0;
          dout_q     <= tx_frame_d[0];
          tx_ready_q <= 1'b0;
          tx_state_q <= TX_SETUP;
        end
        // Data has been on the wire for one cycle with Request low.
        TX_SETUP: begin
          req_q      <= 1'b1;
          tx_cnt_q   <= '0;
          tx_state_q <= TX_REQ;
        end
        TX_REQ: begin
          if (ack_s) begin
            req_q      <= 1'b0;
            tx_cnt_q   <= '0;
            tx_state_q <= TX_REL;
          end else if (tx_cnt_q == TO_MAX) begin
            req_q      <= 1'b0;
            tx_to_q    <= 1'b1;
            tx_ready_q <= 1'b1;
            tx_cnt_q   <= '0;
            tx_state_q <= TX_IDLE;
          end else begin
            tx_cnt_q <= tx_cnt_q + CNT_W'(1);
          end
        end
        TX_REL: begin
          if (!ack_s) begin
            tx_cnt_q <= '0;
            if (tx_wi_q == LAST_IDX) begin
              tx_done_q  <= 1'b1;
              tx_ready_q <= 1'b1;
              tx_state_q <= TX_IDLE;
            end else begin
              tx_wi_q    <= tx_wi_q + IDX_W'(1);
              dout_q     <= tx_frame_q[tx_wi_q + IDX_W'(1)];
              tx_state_q <= TX_SETUP;
            end
          end else if (tx_cnt_q == TO_MAX) begin
            tx_to_q    <= 1'b1;
            tx_ready_q <= 1'b1;
            tx_cnt_q   <= '0;
            tx_state_q <= TX_IDLE;
          end else begin
            tx_cnt_q <= tx_cnt_q + CNT_W'(1);
          end
        end
      endcase
    end
  end

  // ---------------- RX channel ----------------
  rx_state_e                       rx_state_q;
  logic [FRAME_W-1:0][DATA_W-1:0]  rx_slot_q;
  logic [IDX_W-1:0]                rx_ri_q;
  logic [CNT_W-1:0]                rx_cnt_q;
  logic                            ack_q, rx_valid_q;
  logic [MSG_WORDS*DATA_W-1:0]     rx_msg_q;

`ifdef INTERBOARD_CHECKSUM_EN
  logic              rx_err_q;
  logic [DATA_W-1:0] rx_sum;

  always_comb begin
    rx_sum = '0;
    for (int i = 0; i < int'(MSG_WORDS); i++) rx_sum = rx_sum ^ rx_slot_q[i];
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state_q <= RX_WAIT_REQ;
      rx_slot_q  <= '0;
      rx_ri_q    <= '0;
      rx_cnt_q   <= '0;
      ack_q      <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_msg_q   <= '0;
`ifdef INTERBOARD_CHECKSUM_EN
      rx_err_q   <= 1'b0;
`endif
    end else begin
      rx_valid_q <= 1'b0;
`ifdef INTERBOARD_CHECKSUM_EN
      rx_err_q   <= 1'b0;
`endif
      unique case (rx_state_q)
        RX_WAIT_REQ: begin
          if (req_s) begin
            // Request has passed the synchroniser, so data is long stable.
            rx_slot_q[rx_ri_q] <= inter_data_in;
            ack_q              <= 1'b1;
            rx_cnt_q           <= '0;
            rx_state_q         <= RX_ACK;
          end else if (rx_ri_q != '0) begin
            // Mid-frame gap: give up on the partial frame after the timeout.
            if (rx_cnt_q == TO_MAX) begin
              rx_ri_q  <= '0;
              rx_cnt_q <= '0;
            end else begin
              rx_cnt_q <= rx_cnt_q + CNT_W'(1);
            end
          end
        end
        RX_ACK: begin
          if (!req_s) begin
            ack_q      <= 1'b0;
            rx_cnt_q   <= '0;
            rx_state_q <= RX_WAIT_REQ;
            if (rx_ri_q == LAST_IDX) begin
              rx_ri_q <= '0;
`ifdef INTERBOARD_CHECKSUM_EN
              if (rx_sum == rx_slot_q[CHK_IDX]) begin
                rx_valid_q <= 1'b1;
                rx_msg_q   <= rx_slot_q[MSG_WORDS-1:0];
              end else begin
                rx_err_q <= 1'b1;
              end
`else
              rx_valid_q <= 1'b1;
              rx_msg_q   <= rx_slot_q[MSG_WORDS-1:0];
`endif
            end else begin
              rx_ri_q <= rx_ri_q + IDX_W'(1);
            end
          end else if (rx_cnt_q == TO_MAX) begin
            ack_q      <= 1'b0;
            rx_ri_q    <= '0;
            rx_cnt_q   <= '0;
            rx_state_q <= RX_WAIT_REQ;
          end else begin
            rx_cnt_q <= rx_cnt_q + CNT_W'(1);
          end
        end
      endcase
    end
  end

  assign tx_ready       = tx_ready_q;
  assign tx_done        = tx_done_q;
  assign tx_timeout     = tx_to_q;
  assign Request_out    = req_q;
  assign inter_data_out = dout_q;
  assign Ack_out        = ack_q;
  assign rx_valid       = rx_valid_q;
  assign rx_msg         = rx_msg_q;
`ifdef INTERBOARD_CHECKSUM_EN
  assign rx_err         = rx_err_q;
`else
  assign rx_err         = 1'b0;
`endif

endmodule

// File: tb/tb_interboard_link_n.sv
// Bench: two links cross-wired (A <-> B) plus a lone link C whose peer never
// acknowledges. A frame-level model (queues of expected frames, last good
// message per side, busy flags) is checked against the DUTs every cycle.
module tb_interboard_link_n;

  localparam int DW   = 6;
  localparam int MW   = 4;
  localparam int TO   = 100;
  localparam int MSGW = DW * MW;
`ifdef INTERBOARD_CHECKSUM_EN
  localparam int FW = MW + 1;
`else
  localparam int FW = MW;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic            a_tx_valid, a_tx_ready, a_tx_done, a_tx_timeout, a_req, a_ack, a_rx_valid, a_rx_err;
  logic            b_tx_valid, b_tx_ready, b_tx_done, b_tx_timeout, b_req, b_ack, b_rx_valid, b_rx_err;
  logic            c_tx_valid, c_tx_ready, c_tx_done, c_tx_timeout, c_req, c_ack, c_rx_valid, c_rx_err;
  logic [MSGW-1:0] a_tx_msg, a_rx_msg, b_tx_msg, b_rx_msg, c_tx_msg, c_rx_msg;
  logic [DW-1:0]   a_dout, b_dout, c_dout, flip_ab;

  logic corrupt = 1'b0;
  int   a_rise  = 0;
  int   b_rise  = 0;
  // Wire fault injection: bit 0 flipped while A's second word is on the wire.
  assign flip_ab = (corrupt && a_rise == 2) ? DW'(1) : '0;

  interboard_link_n #(.DATA_W(DW), .MSG_WORDS(MW), .TIMEOUT_CYC(TO), .SYNC_STAGES(2)) u_a (
    .clk(clk), .rst(rst), .tx_valid(a_tx_valid), .tx_msg(a_tx_msg), .tx_ready(a_tx_ready),
    .tx_done(a_tx_done), .tx_timeout(a_tx_timeout), .Request_in(b_req), .Ack_in(b_ack),
    .inter_data_in(b_dout), .Request_out(a_req), .Ack_out(a_ack), .inter_data_out(a_dout),
    .rx_valid(a_rx_valid), .rx_msg(a_rx_msg), .rx_err(a_rx_err));

  interboard_link_n #(.DATA_W(DW), .MSG_WORDS(MW), .TIMEOUT_CYC(TO), .SYNC_STAGES(2)) u_b (
    .clk(clk), .rst(rst), .tx_valid(b_tx_valid), .tx_msg(b_tx_msg), .tx_ready(b_tx_ready),
    .tx_done(b_tx_done), .tx_timeout(b_tx_timeout), .Request_in(a_req), .Ack_in(a_ack),
    .inter_data_in(a_dout ^ flip_ab), .Request_out(b_req), .Ack_out(b_ack), .inter_data_out(b_dout),
    .rx_valid(b_rx_valid), .rx_msg(b_rx_msg), .rx_err(b_rx_err));

  interboard_link_n #(.DATA_W(DW), .MSG_WORDS(MW), .TIMEOUT_CYC(TO), .SYNC_STAGES(2)) u_c (
    .clk(clk), .rst(rst), .tx_valid(c_tx_valid), .tx_msg(c_tx_msg), .tx_ready(c_tx_ready),
    .tx_done(c_tx_done), .tx_timeout(c_tx_timeout), .Request_in(1'b0), .Ack_in(1'b0),
    .inter_data_in('0), .Request_out(c_req), .Ack_out(c_ack), .inter_data_out(c_dout),
    .rx_valid(c_rx_valid), .rx_msg(c_rx_msg), .rx_err(c_rx_err));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- frame-level model ----------------
  typedef struct packed { logic [MSGW-1:0] msg; logic bad; } exp_t;
  exp_t            exp_a[$], exp_b[$];
  exp_t            e;
  logic [MSGW-1:0] good_a = '0, good_b = '0, pmsg_a, pmsg_b;
  bit              busy_a = 0, busy_b = 0, pend_a = 0, pend_b = 0, pbad_a = 0, rst_prev = 1;
  logic            a_req_p = 1'b0, b_req_p = 1'b0;
  logic [DW-1:0]   a_dout_p = '0, b_dout_p = '0;
  int a_done_n = 0, b_done_n = 0, a_val_n = 0, b_val_n = 0, a_err_n = 0, b_err_n = 0;

  always @(negedge clk) begin
    if (rst_prev) begin
      exp_a.delete(); exp_b.delete();
      busy_a = 0; busy_b = 0; good_a = '0; good_b = '0; a_rise = 0; b_rise = 0;
      chk("rst_req_a", a_req, 0);   chk("rst_ack_a", a_ack, 0);   chk("rst_dout_a", a_dout, 0);
      chk("rst_req_b", b_req, 0);   chk("rst_ack_b", b_ack, 0);   chk("rst_dout_b", b_dout, 0);
      chk("rst_ready_c", c_tx_ready, 1); chk("rst_dout_c", c_dout, 0);
    end
    // Accepts sampled at the edge just passed.
    if (pend_a) begin e.msg = pmsg_a; e.bad = pbad_a; exp_b.push_back(e); busy_a = 1; a_rise = 0; end
    if (pend_b) begin e.msg = pmsg_b; e.bad = 1'b0;   exp_a.push_back(e); busy_b = 1; b_rise = 0; end

    // Receive side of B (frames from A)
    if (b_rx_valid || b_rx_err) begin
      chk("b_rx_expected", exp_b.size() != 0, 1);
      chk("b_rx_both", b_rx_valid & b_rx_err, 0);
      if (exp_b.size() != 0) begin
        e = exp_b.pop_front();
        chk("b_rx_kind_err", b_rx_err, e.bad);
        if (!e.bad) good_b = e.msg;
      end
      if (b_rx_valid) b_val_n++;
      if (b_rx_err)   b_err_n++;
    end
    chk("b_rx_msg", b_rx_msg, good_b);
    // Receive side of A (frames from B)
    if (a_rx_valid || a_rx_err) begin
      chk("a_rx_expected", exp_a.size() != 0, 1);
      chk("a_rx_both", a_rx_valid & a_rx_err, 0);
      if (exp_a.size() != 0) begin
        e = exp_a.pop_front();
        chk("a_rx_kind_err", a_rx_err, e.bad);
        if (!e.bad) good_a = e.msg;
      end
      if (a_rx_valid) a_val_n++;
      if (a_rx_err)   a_err_n++;
    end
    chk("a_rx_msg", a_rx_msg, good_a);

    // Transmit sides
    if (a_req) chk("a_data_stable", a_dout, a_dout_p);
    if (b_req) chk("b_data_stable", b_dout, b_dout_p);
    if (a_req && !a_req_p) a_rise++;
    if (b_req && !b_req_p) b_rise++;
    if (a_tx_done) begin a_done_n++; chk("a_done_busy", busy_a, 1); chk("a_req_edges", a_rise, FW); busy_a = 0; end
    if (b_tx_done) begin b_done_n++; chk("b_done_busy", busy_b, 1); chk("b_req_edges", b_rise, FW); busy_b = 0; end
    chk("a_timeout", a_tx_timeout, 0);
    chk("b_timeout", b_tx_timeout, 0);
    chk("a_ready", a_tx_ready, !busy_a);
    chk("b_ready", b_tx_ready, !busy_b);
    chk("c_rx_quiet", {c_rx_valid, c_rx_err, c_ack, c_tx_done}, 0);
    chk("c_rx_msg", c_rx_msg, 0);

    pend_a   = !rst && a_tx_valid && a_tx_ready; pmsg_a = a_tx_msg; pbad_a = corrupt;
    pend_b   = !rst && b_tx_valid && b_tx_ready; pmsg_b = b_tx_msg;
    a_req_p  = a_req;  b_req_p  = b_req;
    a_dout_p = a_dout; b_dout_p = b_dout;
    rst_prev = rst;
  end

  // ---------------- stimulus ----------------
  task automatic start(input bit sa, input logic [MSGW-1:0] ma, input bit sb, input logic [MSGW-1:0] mb);
    @(posedge clk); #1;
    if (sa) begin a_tx_valid = 1'b1; a_tx_msg = ma; end
    if (sb) begin b_tx_valid = 1'b1; b_tx_msg = mb; end
    @(posedge clk); #1;
    a_tx_valid = 1'b0; b_tx_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk); #1; n++;
    end while ((busy_a || busy_b || exp_a.size() != 0 || exp_b.size() != 0) && n < 3000);
    chk({name, "_complete"}, n < 3000, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (total=%0d bad=%0d)", total, bad);
    $fatal(1);
  end

  initial begin
    int n, k, v0, vb0, d0, db0, e0, mode, off;
    bit prev;
    logic [MSGW-1:0] ma, mb;
    a_tx_valid = 0; b_tx_valid = 0; c_tx_valid = 0;
    a_tx_msg = '0; b_tx_msg = '0; c_tx_msg = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk); #1;
    chk("reset_tx_ready_a", a_tx_ready, 1);
    chk("reset_rx_msg_b", b_rx_msg, 0);
    chk("reset_pulses", {a_tx_done, a_tx_timeout, b_rx_valid, b_rx_err}, 0);

    // Basic frame A -> B
    v0 = b_val_n; d0 = a_done_n; vb0 = a_val_n;
    start(1, 24'hABCDEF, 0, '0);
    wait_idle("basic");
    chk("basic_rx_msg", b_rx_msg, 24'hABCDEF);
    chk("basic_rx_valid_cnt", b_val_n - v0, 1);
    chk("basic_done_cnt", a_done_n - d0, 1);
    chk("basic_req_edges", a_rise, FW);
    chk("basic_no_reverse", a_val_n - vb0, 0);

    // TX timeout on C (peer never acks)
    @(posedge clk); #1 c_tx_valid = 1'b1; c_tx_msg = 24'h777777;
    @(posedge clk); #1 c_tx_valid = 1'b0;
    n = 0;
    while (!c_req && n < 20) begin @(negedge clk); n++; end
    chk("to_req_seen", c_req, 1);
    n = 0;
    do begin @(negedge clk); n++; end while (!c_tx_timeout && n < 300);
    chk("to_latency", n, 100);
    chk("to_req_low", c_req, 0);
    chk("to_ready", c_tx_ready, 1);
    @(negedge clk);
    chk("to_single_pulse", c_tx_timeout, 0);

    // Simultaneous full-duplex
    d0 = a_done_n; db0 = b_done_n;
    start(1, 24'h123456, 1, 24'h0FEDCB);
    wait_idle("duplex");
    chk("duplex_b_rx", b_rx_msg, 24'h123456);
    chk("duplex_a_rx", a_rx_msg, 24'h0FEDCB);
    chk("duplex_dones", (a_done_n - d0) + (b_done_n - db0), 2);

    // Reset after 2nd word acknowledged
    start(1, 24'h3C3C3C, 0, '0);
    n = 0; k = 0; prev = 0;
    while (k < 2 && n < 500) begin
      @(negedge clk); #1; n++;
      if (b_ack && !prev) k++;
      prev = b_ack;
    end
    chk("rst_mid_reached", k, 2);
    v0 = b_val_n; d0 = a_done_n; e0 = b_err_n;
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk); #1;
    chk("rst_mid_ready", a_tx_ready, 1);
    chk("rst_mid_rx_msg", b_rx_msg, 0);
    chk("rst_mid_handshake", {a_req, b_ack}, 0);
    repeat (20) @(negedge clk);
    #1 chk("rst_mid_no_pulses", (b_val_n - v0) + (a_done_n - d0) + (b_err_n - e0), 0);
    start(1, 24'h000001, 0, '0);
    wait_idle("after_rst");
    chk("after_rst_rx", b_rx_msg, 24'h000001);

    // tx_valid while busy is ignored
    v0 = b_val_n; d0 = a_done_n;
    start(1, 24'h5A5A5A, 0, '0);
    repeat (8) @(posedge clk);
    #1 a_tx_valid = 1'b1; a_tx_msg = 24'hFFFFFF;
    repeat (4) @(posedge clk);
    #1 a_tx_valid = 1'b0;
    wait_idle("busy_ignore");
    repeat (60) @(negedge clk);
    #1;
    chk("busy_ignore_rx", b_rx_msg, 24'h5A5A5A);
    chk("busy_ignore_cnt", b_val_n - v0, 1);
    chk("busy_ignore_done", a_done_n - d0, 1);

`ifdef INTERBOARD_CHECKSUM_EN
    // Checksum: corrupt word 1 on the A -> B wire
    start(1, 24'h111111, 0, '0);
    wait_idle("chk_pre");
    v0 = b_val_n; e0 = b_err_n;
    corrupt = 1'b1;
    start(1, 24'h222222, 0, '0);
    wait_idle("chk_bad");
    corrupt = 1'b0;
    chk("chk_err_cnt", b_err_n - e0, 1);
    chk("chk_no_valid", b_val_n - v0, 0);
    chk("chk_msg_kept", b_rx_msg, 24'h111111);
    start(1, 24'h333333, 0, '0);
    wait_idle("chk_post");
    chk("chk_recover_cnt", b_val_n - v0, 1);
    chk("chk_recover_msg", b_rx_msg, 24'h333333);
`endif

    // Randomised traffic: one-way either direction and staggered full duplex
    for (int it = 0; it < 24; it++) begin
      ma   = MSGW'($urandom);
      mb   = MSGW'($urandom);
      mode = int'($urandom_range(0, 2));
      off  = int'($urandom_range(0, 15));
      if (mode == 0) start(1, ma, 0, '0);
      else if (mode == 1) start(0, '0, 1, mb);
      else begin
        start(1, ma, 0, '0);
        repeat (off) @(posedge clk);
        start(0, '0, 1, mb);
      end
      wait_idle("rand");
    end

    chk("end_queues_empty", exp_a.size() + exp_b.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
